spu32_wb8_arbiter2: RTL and testbench
=====================================

// Module: spu32_wb8_arbiter2
// PURPOSE
//  Two-master arbiter sharing one 8-bit pipelined Wishbone B4 slave port (RAM/devices).
//  M0 is typically the CPU byte-bus adapter, M1 a secondary master (DMA, video fetch).
//  Grants the bus per Wishbone cycle (CYC), tracks outstanding strobes and returns
//  a synthetic ACK on slave timeout so a dead device cannot hang a master.
// PARAMETERS
//  ROUND_ROBIN      1   1: alternate on simultaneous requests; 0: M0 fixed priority
//  MAX_OUTSTANDING  4   max accepted-but-unACKed strobes (1..7)
//  TIMEOUT          255 cycles without ACK while outstanding>0 before synthetic ACK; 0 disables
// PORTS
//  I_clk        in   1   clock, all state on rising edge
//  RST_I        in   1   synchronous reset, active high
//  M0_CYC_I / M1_CYC_I    in 1   master cycle request
//  M0_STB_I / M1_STB_I    in 1   master strobe
//  M0_WE_I / M1_WE_I      in 1   master write enable
//  M0_ADR_I / M1_ADR_I    in 32  master address
//  M0_DAT_I / M1_DAT_I    in 8   master write data
//  M0_DAT_O / M1_DAT_O    out 8  read data (DAT_I broadcast; 8'hFF on synthetic ACK)
//  M0_ACK_O / M1_ACK_O    out 1  ACK to master
//  M0_STALL_O / M1_STALL_O out 1 STALL to master
//  CYC_O STB_O WE_O       out 1  slave-side Wishbone controls
//  ADR_O        out  32  slave address;  DAT_O out 8 slave write data
//  DAT_I        in   8   slave read data; ACK_I in 1; STALL_I in 1
//  O_grant      out  2   one-hot current grant (00 = idle)
//  O_timeout    out  1   one-cycle pulse when a synthetic ACK is issued
// BEHAVIOUR
//  - States IDLE, GRANT0, GRANT1 (registered). Slave outputs are a combinational mux of
//    the granted master: CYC_O=Mx_CYC_I, STB_O=Mx_STB_I & ~full, WE_O/ADR_O/DAT_O=Mx.
//    IDLE: CYC_O=STB_O=WE_O=0, ADR_O/DAT_O driven from M0 (don't care).
//  - Non-granted master: STALL_O=1, ACK_O=0. Granted: STALL_O=STALL_I|full, ACK_O=ACK_I|synth.
//  - full = (outstanding==MAX_OUTSTANDING).
//  - IDLE: any CYC sampled high -> GRANTx next edge (1 cycle grant latency). Both high:
//    ROUND_ROBIN=1 -> master other than `last`; else M0. `last` updated on every grant.
//  - GRANTx -> release when Mx_CYC_I==0: outstanding cleared, next state = GRANT(other) if
//    other CYC high, else IDLE. Grant never changes while Mx_CYC_I==1.
//  - outstanding (3b): +1 on STB_O&~STALL_I, -1 on ACK_O to granted master; both -> hold.
//    Master drops CYC with outstanding>0 (abort): counter cleared, late ACK_I ignored.
//  - Timeout counter: cleared on ACK_I, outstanding==0, or grant change; else increments.
//    On reaching TIMEOUT: next cycle ACK_O=1 to granted master, DAT_O=8'hFF, O_timeout=1,
//    outstanding-1, counter cleared. Real ACK_I in that same cycle wins: no pulse.
//  - Reset (any time, incl. mid-transfer): state IDLE, last=M1 (M0 wins first tie),
//    outstanding=0, timer=0, O_timeout=0, O_grant=00; CYC_O/STB_O low the cycle after.
// TESTING
//  1 M0 alone: CYC/STB 4 reads ADR 0x100..0x103, slave ACKs 1 cycle later -> O_grant=01
//    one cycle after CYC, 4 ACKs with DAT 0x11,0x22,0x33,0x44, outstanding back to 0.
//  2 M0,M1 CYC same cycle, ROUND_ROBIN=1 -> M0 first, M1 STALL_O=1 throughout; M0 drops
//    CYC -> O_grant=10 next edge; repeat -> M1 wins tie second round. RR=0 -> M0 both.
//  3 STALL_I held 3 cycles mid-burst -> granted STALL_O=1, ADR_O stable, no count change.
//  4 MAX_OUTSTANDING=2, slave never ACKs early -> 3rd strobe stalled until one ACK returns.
//  5 TIMEOUT=8, slave silent after 1 strobe -> synthetic ACK 9 cycles later, DAT 0xFF,
//    O_timeout 1 cycle; ACK_I on that exact cycle -> real data, no pulse.
//  6 RST_I during GRANT1 with 2 outstanding -> O_grant=00, CYC_O=0 next cycle, stray ACK_I
//    ignored, next M0 request granted normally.

Source files
------------

// File: rtl/spu32_wb8_arbiter2.sv
// Two-master arbiter in front of one 8-bit pipelined Wishbone B4 slave.
// Grants per CYC, counts outstanding strobes, and fakes an ACK when the slave goes silent.
module spu32_wb8_arbiter2 #(
  parameter int ROUND_ROBIN     = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic        I_clk,
  input  logic        RST_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [7:0]  M0_DAT_I,
  output logic [7:0]  M0_DAT_O,
  output logic        M0_ACK_O,
  output logic        M0_STALL_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [7:0]  M1_DAT_I,
  output logic [7:0]  M1_DAT_O,
  output logic        M1_ACK_O,
  output logic        M1_STALL_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [7:0]  DAT_O,
  input  logic [7:0]  DAT_I,
  input  logic        ACK_I,
  input  logic        STALL_I,
  output logic [1:0]  O_grant,
  output logic        O_timeout
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t          state, state_nx;
  logic            last, last_nx;   // 0: M0 was granted most recently
  logic [2:0]      outstanding;
  logic [TW-1:0]   timer;

  logic granted, sel, m_cyc, m_stb, m_we;
  logic full, synth, rel, accept, ack_g, dec;

  assign granted = (state != IDLE);
  assign sel     = (state == GRANT1);
  assign m_cyc   = sel ? M1_CYC_I : M0_CYC_I;
  assign m_stb   = sel ? M1_STB_I : M0_STB_I;
  assign m_we    = sel ? M1_WE_I  : M0_WE_I;
  assign full    = (outstanding == 3'(MAX_OUTSTANDING));

  // A real ACK arriving on the expiry cycle takes precedence over the synthetic one.
  assign synth = (TIMEOUT != 0) && granted && m_cyc && (outstanding != 3'd0) &&
                 (timer == TW'(TIMEOUT)) && !ACK_I;

  assign CYC_O = granted & m_cyc;
  assign STB_O = granted & m_stb & ~full;
  assign WE_O  = granted & m_we;
  assign ADR_O = sel ? M1_ADR_I : M0_ADR_I;
  assign DAT_O = sel ? M1_DAT_I : M0_DAT_I;

  assign M0_DAT_O   = synth ? 8'hFF : DAT_I;
  assign M1_DAT_O   = synth ? 8'hFF : DAT_I;
  assign M0_ACK_O   = (state == GRANT0) & (ACK_I | synth);
  assign M1_ACK_O   = (state == GRANT1) & (ACK_I | synth);
  assign M0_STALL_O = (state == GRANT0) ? (STALL_I | full) : 1'b1;
  assign M1_STALL_O = (state == GRANT1) ? (STALL_I | full) : 1'b1;
  assign O_grant    = {state == GRANT1, state == GRANT0};
  assign O_timeout  = synth;

  assign rel    = granted & ~m_cyc;
  assign accept = STB_O & ~STALL_I;
  assign ack_g  = granted & (ACK_I | synth);
  assign dec    = ack_g & (outstanding != 3'd0);

  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (M0_CYC_I && M1_CYC_I)
          state_nx = (ROUND_ROBIN != 0 && !last) ? GRANT1 : GRANT0;
        else if (M0_CYC_I)
          state_nx = GRANT0;
        else if (M1_CYC_I)
          state_nx = GRANT1;
      end
      GRANT0:  if (!M0_CYC_I) state_nx = M1_CYC_I ? GRANT1 : IDLE;
      GRANT1:  if (!M1_CYC_I) state_nx = M0_CYC_I ? GRANT0 : IDLE;
      default: state_nx = IDLE;
    endcase
    if (state_nx == GRANT0 && state != GRANT0) last_nx = 1'b0;
    if (state_nx == GRANT1 && state != GRANT1) last_nx = 1'b1;
  end

  always_ff @(posedge I_clk) begin
    if (RST_I) begin
      state       <= IDLE;
      last        <= 1'b1;
      outstanding <= 3'd0;
      timer       <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      // Dropping CYC abandons whatever is in flight; late slave ACKs find nothing to retire.
      if (rel)
        outstanding <= 3'd0;
      else if (accept && !dec)
        outstanding <= outstanding + 3'd1;
      else if (dec && !accept)
        outstanding <= outstanding - 3'd1;
      if (TIMEOUT == 0 || rel || ACK_I || outstanding == 3'd0 || synth)
        timer <= '0;
      else
        timer <= timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_spu32_wb8_arbiter2.sv
// Bench for spu32_wb8_arbiter2: two configurations run side by side against a
// cycle-level reference model, plus vector tables and directed corner sequences.
module tb_spu32_wb8_arbiter2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mc[2], ms[2], mw[2];
  logic [31:0] ma[2];
  logic [7:0]  md[2];
  logic [7:0]  dat_i;
  logic        ack_i, stall_i;

  logic [7:0]  o_d0[2], o_d1[2], o_dat[2];
  logic        o_a0[2], o_a1[2], o_s0[2], o_s1[2];
  logic        o_cyc[2], o_stb[2], o_we[2], o_tmo[2];
  logic [31:0] o_adr[2];
  logic [1:0]  o_gnt[2];

  // A: round robin, shallow pipeline, short timeout. B: fixed priority, defaults.
  spu32_wb8_arbiter2 #(.ROUND_ROBIN(1), .MAX_OUTSTANDING(2), .TIMEOUT(8)) u_a (
    .I_clk(clk), .RST_I(rst),
    .M0_CYC_I(mc[0]), .M0_STB_I(ms[0]), .M0_WE_I(mw[0]), .M0_ADR_I(ma[0]), .M0_DAT_I(md[0]),
    .M0_DAT_O(o_d0[0]), .M0_ACK_O(o_a0[0]), .M0_STALL_O(o_s0[0]),
    .M1_CYC_I(mc[1]), .M1_STB_I(ms[1]), .M1_WE_I(mw[1]), .M1_ADR_I(ma[1]), .M1_DAT_I(md[1]),
    .M1_DAT_O(o_d1[0]), .M1_ACK_O(o_a1[0]), .M1_STALL_O(o_s1[0]),
    .CYC_O(o_cyc[0]), .STB_O(o_stb[0]), .WE_O(o_we[0]), .ADR_O(o_adr[0]), .DAT_O(o_dat[0]),
    .DAT_I(dat_i), .ACK_I(ack_i), .STALL_I(stall_i),
    .O_grant(o_gnt[0]), .O_timeout(o_tmo[0]));

  spu32_wb8_arbiter2 #(.ROUND_ROBIN(0), .MAX_OUTSTANDING(4), .TIMEOUT(255)) u_b (
    .I_clk(clk), .RST_I(rst),
    .M0_CYC_I(mc[0]), .M0_STB_I(ms[0]), .M0_WE_I(mw[0]), .M0_ADR_I(ma[0]), .M0_DAT_I(md[0]),
    .M0_DAT_O(o_d0[1]), .M0_ACK_O(o_a0[1]), .M0_STALL_O(o_s0[1]),
    .M1_CYC_I(mc[1]), .M1_STB_I(ms[1]), .M1_WE_I(mw[1]), .M1_ADR_I(ma[1]), .M1_DAT_I(md[1]),
    .M1_DAT_O(o_d1[1]), .M1_ACK_O(o_a1[1]), .M1_STALL_O(o_s1[1]),
    .CYC_O(o_cyc[1]), .STB_O(o_stb[1]), .WE_O(o_we[1]), .ADR_O(o_adr[1]), .DAT_O(o_dat[1]),
    .DAT_I(dat_i), .ACK_I(ack_i), .STALL_I(stall_i),
    .O_grant(o_gnt[1]), .O_timeout(o_tmo[1]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int p_rr(input int k);  return (k == 0) ? 1 : 0;   endfunction
  function automatic int p_max(input int k); return (k == 0) ? 2 : 4;   endfunction
  function automatic int p_to(input int k);  return (k == 0) ? 8 : 255; endfunction

  int own[2];   // -1 nobody, else index of the master holding the bus
  int last[2];
  int outs[2];
  int tmr[2];

  typedef struct {
    logic cyc, stb, we;
    logic [31:0] adr;
    logic [7:0]  dat, rd;
    logic a0, a1, s0, s1;
    logic [1:0] gnt;
    logic tmo;
  } exp_t;

  function automatic exp_t model_out(input int k);
    exp_t e;
    int o;
    logic full, syn, ack;
    o    = own[k];
    full = (outs[k] == p_max(k));
    syn  = 1'b0;
    e.adr = (o == 1) ? ma[1] : ma[0];
    e.dat = (o == 1) ? md[1] : md[0];
    e.cyc = 1'b0; e.stb = 1'b0; e.we = 1'b0;
    e.a0 = 1'b0; e.a1 = 1'b0; e.s0 = 1'b1; e.s1 = 1'b1; e.gnt = 2'b00;
    if (o >= 0) begin
      e.cyc = mc[o];
      e.stb = ms[o] & ~full;
      e.we  = mw[o];
      syn   = (p_to(k) != 0) && mc[o] && outs[k] > 0 && tmr[k] == p_to(k) && !ack_i;
      ack   = ack_i | syn;
      if (o == 0) begin e.a0 = ack; e.s0 = stall_i | full; e.gnt = 2'b01; end
      else        begin e.a1 = ack; e.s1 = stall_i | full; e.gnt = 2'b10; end
    end
    e.tmo = syn;
    e.rd  = syn ? 8'hFF : dat_i;
    return e;
  endfunction

  task automatic model_edge(input int k);
    exp_t e;
    int o, w, acc, dec;
    e = model_out(k);
    o = own[k];
    if (rst) begin
      own[k] = -1; last[k] = 1; outs[k] = 0; tmr[k] = 0;
    end else if (o < 0) begin
      w = -1;
      if (mc[0] && mc[1]) w = (p_rr(k) != 0 && last[k] == 0) ? 1 : 0;
      else if (mc[0])     w = 0;
      else if (mc[1])     w = 1;
      if (w >= 0) begin own[k] = w; last[k] = w; end
    end else if (!mc[o]) begin
      outs[k] = 0;
      tmr[k]  = 0;
      own[k]  = mc[1 - o] ? 1 - o : -1;
      if (own[k] >= 0) last[k] = own[k];
    end else begin
      acc = (e.stb && !stall_i) ? 1 : 0;
      dec = (((o == 0) ? e.a0 : e.a1) && outs[k] > 0) ? 1 : 0;
      if (ack_i || outs[k] == 0 || e.tmo || p_to(k) == 0) tmr[k] = 0;
      else tmr[k] = tmr[k] + 1;
      outs[k] = outs[k] + acc - dec;
    end
  endtask

  task automatic check_dut(input int k);
    exp_t e;
    string p;
    e = model_out(k);
    p = (k == 0) ? "A" : "B";
    chk({p, ".cyc_o"},  32'(o_cyc[k]), 32'(e.cyc));
    chk({p, ".stb_o"},  32'(o_stb[k]), 32'(e.stb));
    chk({p, ".we_o"},   32'(o_we[k]),  32'(e.we));
    chk({p, ".adr_o"},  o_adr[k],      e.adr);
    chk({p, ".dat_o"},  32'(o_dat[k]), 32'(e.dat));
    chk({p, ".m0_dat"}, 32'(o_d0[k]),  32'(e.rd));
    chk({p, ".m1_dat"}, 32'(o_d1[k]),  32'(e.rd));
    chk({p, ".ack0"},   32'(o_a0[k]),  32'(e.a0));
    chk({p, ".ack1"},   32'(o_a1[k]),  32'(e.a1));
    chk({p, ".stall0"}, 32'(o_s0[k]),  32'(e.s0));
    chk({p, ".stall1"}, 32'(o_s1[k]),  32'(e.s1));
    chk({p, ".grant"},  32'(o_gnt[k]), 32'(e.gnt));
    chk({p, ".tmo"},    32'(o_tmo[k]), 32'(e.tmo));
  endtask

  // samples of DUT A taken mid-cycle by the last step()
  logic        smp_a0, smp_a1, smp_s0, smp_s1, smp_cyc, smp_stb, smp_tmo;
  logic [7:0]  smp_rd;
  logic [31:0] smp_adr;
  logic [1:0]  smp_gnt;

  task automatic step();
    #2;
    check_dut(0);
    check_dut(1);
    smp_a0 = o_a0[0]; smp_a1 = o_a1[0]; smp_s0 = o_s0[0]; smp_s1 = o_s1[0];
    smp_cyc = o_cyc[0]; smp_stb = o_stb[0]; smp_tmo = o_tmo[0];
    smp_rd = o_d0[0]; smp_adr = o_adr[0]; smp_gnt = o_gnt[0];
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic drive(input int m, input logic c, input logic s);
    mc[m] = c;
    ms[m] = s;
  endtask

  task automatic idle_inputs();
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    ack_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, m0c, m0s, m1c, m1s, ack, stall;
    logic [7:0] dat;
    logic [31:0] adr0;
    logic [1:0] gnt;
    logic cyc, stb, a0, a1, s0, s1;
    logic [7:0] rd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input logic r, input logic m0c, input logic m0s, input logic m1c,
                             input logic m1s, input logic ack, input logic stall,
                             input logic [7:0] dat, input logic [31:0] adr0,
                             input logic [1:0] gnt, input logic cyc, input logic stb,
                             input logic a0, input logic a1, input logic s0, input logic s1,
                             input logic [7:0] rd);
    vec_t t;
    t.rst = r; t.m0c = m0c; t.m0s = m0s; t.m1c = m1c; t.m1s = m1s; t.ack = ack;
    t.stall = stall; t.dat = dat; t.adr0 = adr0; t.gnt = gnt; t.cyc = cyc; t.stb = stb;
    t.a0 = a0; t.a1 = a1; t.s0 = s0; t.s1 = s1; t.rd = rd;
    return t;
  endfunction

  initial begin
    int seen;
    // M0 alone: four pipelined reads, slave answers one cycle behind
    tv.push_back(v(0,1,1,0,0,0,0,8'h00,32'h100, 2'b00,0,0,0,0,1,1,8'h00));
    tv.push_back(v(0,1,1,0,0,0,0,8'h00,32'h100, 2'b01,1,1,0,0,0,1,8'h00));
    tv.push_back(v(0,1,1,0,0,1,0,8'h11,32'h101, 2'b01,1,1,1,0,0,1,8'h11));
    tv.push_back(v(0,1,1,0,0,1,0,8'h22,32'h102, 2'b01,1,1,1,0,0,1,8'h22));
    tv.push_back(v(0,1,1,0,0,1,0,8'h33,32'h103, 2'b01,1,1,1,0,0,1,8'h33));
    tv.push_back(v(0,1,0,0,0,1,0,8'h44,32'h103, 2'b01,1,0,1,0,0,1,8'h44));
    tv.push_back(v(0,0,0,0,0,0,0,8'h00,32'h103, 2'b01,0,0,0,0,0,1,8'h00));
    tv.push_back(v(0,0,0,0,0,0,0,8'h00,32'h103, 2'b00,0,0,0,0,1,1,8'h00));
    tv.push_back(v(1,0,0,0,0,0,0,8'h00,32'h000, 2'b00,0,0,0,0,1,1,8'h00));
    // simultaneous requests, handoff, then a tie that round robin gives to M1
    tv.push_back(v(0,1,0,1,0,0,0,8'h00,32'h110, 2'b00,0,0,0,0,1,1,8'h00));
    tv.push_back(v(0,1,1,1,0,0,0,8'h00,32'h110, 2'b01,1,1,0,0,0,1,8'h00));
    tv.push_back(v(0,1,0,1,0,1,0,8'h55,32'h110, 2'b01,1,0,1,0,0,1,8'h55));
    tv.push_back(v(0,0,0,1,0,0,0,8'h00,32'h110, 2'b01,0,0,0,0,0,1,8'h00));
    tv.push_back(v(0,0,0,1,1,0,0,8'h00,32'h110, 2'b10,1,1,0,0,1,0,8'h00));
    tv.push_back(v(0,0,0,1,0,1,0,8'h66,32'h110, 2'b10,1,0,0,1,1,0,8'h66));
    tv.push_back(v(0,0,0,0,0,0,0,8'h00,32'h110, 2'b10,0,0,0,0,1,0,8'h00));
    tv.push_back(v(0,1,0,1,0,0,0,8'h00,32'h110, 2'b00,0,0,0,0,1,1,8'h00));
    tv.push_back(v(0,1,0,0,0,0,0,8'h00,32'h110, 2'b01,1,0,0,0,0,1,8'h00));
    tv.push_back(v(0,0,0,0,0,0,0,8'h00,32'h110, 2'b01,0,0,0,0,0,1,8'h00));
    tv.push_back(v(0,1,0,1,0,0,0,8'h00,32'h110, 2'b00,0,0,0,0,1,1,8'h00));
    tv.push_back(v(0,1,0,1,0,0,0,8'h00,32'h110, 2'b10,1,0,0,0,1,0,8'h00));
    tv.push_back(v(0,0,0,0,0,0,0,8'h00,32'h110, 2'b10,0,0,0,0,1,0,8'h00));
    tv.push_back(v(0,0,0,0,0,0,0,8'h00,32'h110, 2'b00,0,0,0,0,1,1,8'h00));

    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      mc[m] = 1'b0; ms[m] = 1'b0; mw[m] = 1'b0; ma[m] = 32'h200 * (m + 1); md[m] = 8'h00;
    end
    ack_i = 1'b0; stall_i = 1'b0; dat_i = 8'h00;
    repeat (2) @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    rst = 1'b0;

    // reset state
    step();
    chk("reset.grant", 32'(smp_gnt), 32'd0);
    chk("reset.cyc_o", 32'(smp_cyc), 32'd0);
    chk("reset.stall0", 32'(smp_s0), 32'd1);

    foreach (tv[i]) begin
      rst = tv[i].rst;
      mc[0] = tv[i].m0c; ms[0] = tv[i].m0s; mc[1] = tv[i].m1c; ms[1] = tv[i].m1s;
      ack_i = tv[i].ack; stall_i = tv[i].stall; dat_i = tv[i].dat; ma[0] = tv[i].adr0;
      step();
      chk($sformatf("tv%0d.grant", i),  32'(smp_gnt), 32'(tv[i].gnt));
      chk($sformatf("tv%0d.cyc_o", i),  32'(smp_cyc), 32'(tv[i].cyc));
      chk($sformatf("tv%0d.stb_o", i),  32'(smp_stb), 32'(tv[i].stb));
      chk($sformatf("tv%0d.ack0", i),   32'(smp_a0),  32'(tv[i].a0));
      chk($sformatf("tv%0d.ack1", i),   32'(smp_a1),  32'(tv[i].a1));
      chk($sformatf("tv%0d.stall0", i), 32'(smp_s0),  32'(tv[i].s0));
      chk($sformatf("tv%0d.stall1", i), 32'(smp_s1),  32'(tv[i].s1));
      if (tv[i].a0 || tv[i].a1)
        chk($sformatf("tv%0d.rdata", i), 32'(smp_rd), 32'(tv[i].rd));
    end
    rst = 1'b0;

    // slave stall mid-burst, then outstanding limit of 2 on A
    do_reset();
    drive(0, 1'b1, 1'b1); ma[0] = 32'h300;
    step();
    step();
    chk("t3.first_accept_stall", 32'(smp_s0), 32'd0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3.stall0", 32'(smp_s0), 32'd1);
      chk("t3.adr_stable", smp_adr, 32'h300);
    end
    stall_i = 1'b0; ma[0] = 32'h301;
    step();
    chk("t4.second_accept", 32'(smp_s0), 32'd0);
    ma[0] = 32'h302;
    step();
    chk("t4.full_stall", 32'(smp_s0), 32'd1);
    chk("t4.full_stb_o", 32'(smp_stb), 32'd0);
    ack_i = 1'b1; dat_i = 8'h77;
    step();
    chk("t4.ack_while_full", 32'(smp_a0), 32'd1);
    chk("t4.still_full", 32'(smp_s0), 32'd1);
    ack_i = 1'b0;
    step();
    chk("t4.third_accept", 32'(smp_s0), 32'd0);
    chk("t4.third_stb_o", 32'(smp_stb), 32'd1);
    drive(0, 1'b1, 1'b0); ack_i = 1'b1;
    step(); step();
    ack_i = 1'b0; drive(0, 1'b0, 1'b0);
    step(); step();

    // slave goes silent after one strobe on A (TIMEOUT 8)
    do_reset();
    drive(0, 1'b1, 1'b0);
    step();
    drive(0, 1'b1, 1'b1);
    step();
    drive(0, 1'b1, 1'b0);
    seen = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (smp_a0 && seen == 0) begin
        seen = i;
        chk("t5.synth_data", 32'(smp_rd), 32'hFF);
        chk("t5.synth_pulse", 32'(smp_tmo), 32'd1);
      end
    end
    chk("t5.synth_latency", seen, 32'd9);
    drive(0, 1'b1, 1'b1);
    step();
    drive(0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) step();
    ack_i = 1'b1; dat_i = 8'h5A;
    step();
    chk("t5.real_ack_wins", 32'(smp_a0), 32'd1);
    chk("t5.real_data", 32'(smp_rd), 32'h5A);
    chk("t5.no_pulse", 32'(smp_tmo), 32'd0);
    ack_i = 1'b0; drive(0, 1'b0, 1'b0);
    step(); step();

    // reset while M1 holds the bus with two strobes in flight
    do_reset();
    drive(1, 1'b1, 1'b0);
    step();
    drive(1, 1'b1, 1'b1);
    step(); step();
    drive(1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk("t6.grant_before_reset", 32'(smp_gnt), 32'b10);
    rst = 1'b0; ack_i = 1'b1;
    step();
    chk("t6.grant_after_reset", 32'(smp_gnt), 32'd0);
    chk("t6.cyc_o_after_reset", 32'(smp_cyc), 32'd0);
    chk("t6.stray_ack1", 32'(smp_a1), 32'd0);
    chk("t6.stray_ack0", 32'(smp_a0), 32'd0);
    ack_i = 1'b0;
    drive(0, 1'b1, 1'b1);
    step();
    step();
    chk("t6.m0_grant", 32'(smp_gnt), 32'b01);
    chk("t6.m0_stb_o", 32'(smp_stb), 32'd1);
    drive(0, 1'b0, 1'b0);
    step(); step();

    // random traffic against the model
    for (int blk = 0; blk < 15; blk++) begin
      int ack_rate;
      ack_rate = $urandom_range(1, 6);
      for (int c = 0; c < 200; c++) begin
        rst = ($urandom_range(0, 299) == 0);
        for (int m = 0; m < 2; m++) begin
          if ($urandom_range(0, 7) == 0) mc[m] = ~mc[m];
          ms[m] = 1'($urandom_range(0, 1));
          mw[m] = 1'($urandom_range(0, 1));
          ma[m] = $urandom;
          md[m] = 8'($urandom);
        end
        ack_i   = ($urandom_range(1, ack_rate * 2) == 1);
        stall_i = ($urandom_range(0, 3) == 0);
        dat_i   = 8'($urandom);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
